// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register
// pending-write scoreboard that stalls decode on outstanding producers.
module regfile_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned PW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [31:0]             wd,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  output logic [31:0]             rd1,
  output logic [31:0]             rd2,
  input  logic                    issue,
  input  logic [$clog2(NREG)-1:0] issue_wa,
  input  logic                    flush,
  output logic                    stall,
  output logic [NREG-1:0]         busy
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned DW = 32;
  localparam logic [PW-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0] CNT_ONE = PW'(1);

  logic [DW-1:0] regs [NREG];
  logic [PW-1:0] cnt  [NREG];
  logic          haz1;
  logic          haz2;
  logic          sat;

  // Read ports with write-through bypass; r0 always reads zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
  end

  // A read hazard is waived when the last pending write arrives this cycle.
  always_comb begin
    haz1  = (ra1 != '0) && (cnt[ra1] != '0) &&
            !(we && (wa == ra1) && (cnt[ra1] == CNT_ONE));
    haz2  = (ra2 != '0) && (cnt[ra2] != '0) &&
            !(we && (wa == ra2) && (cnt[ra2] == CNT_ONE));
    sat   = issue && (issue_wa != '0) && (cnt[issue_wa] == CNT_MAX);
    stall = haz1 || haz2 || sat;
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREG; i++) busy[i] = (cnt[i] != '0);
  end

  // Register storage; writes survive a flush but not a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Pending counters: stalled issues are dropped, write-backs never underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned i = 1; i < NREG; i++) begin
        logic inc;
        logic dec;
        inc = issue && !stall && (issue_wa == AW'(i));
        dec = we && (wa == AW'(i)) && (cnt[i] != '0);
        if (flush)              cnt[i] <= '0;
        else if (inc && !dec)   cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec && !inc)   cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, hazards, saturation,
// simultaneous inc/dec, flush and reset behaviour.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        issue;
  logic [4:0]  issue_wa;
  logic        flush;
  logic        stall;
  logic [31:0] busy;

  int passed = 0;
  int total  = 0;

  regfile_scoreboard #(.NREG(32), .PW(2)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .issue(issue), .issue_wa(issue_wa), .flush(flush),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and leave inputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    issue = 1'b0; issue_wa = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state across all addresses
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
    end
    check("reset_busy", busy, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);

    // Bypass on r5, then from storage
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd0;
    #1 check("bypass_same_cycle", rd1, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1 check("bypass_next_cycle", rd1, 32'hDEADBEEF);

    // Writes to r0 are ignored
    we = 1'b1; wa = 5'd0; wd = 32'hCAFEF00D; ra1 = 5'd0;
    #1 check("r0_same_cycle", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1 check("r0_next_cycle", rd1, 32'h0);

    // Hazard on r7
    issue = 1'b1; issue_wa = 5'd7;
    #1 check("haz_issue_nostall", {31'h0, stall}, 32'h0);
    tick();
    issue = 1'b0; ra2 = 5'd7;
    #1 check("haz_stall", {31'h0, stall}, 32'h1);
    check("haz_busy7", {31'h0, busy[7]}, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h1234;
    #1 check("haz_wb_release", {31'h0, stall}, 32'h0);
    check("haz_wb_rd2", rd2, 32'h1234);
    tick();
    we = 1'b0;
    #1 check("haz_busy7_clear", {31'h0, busy[7]}, 32'h0);
    check("haz_rd2_stored", rd2, 32'h1234);
    ra2 = 5'd0;

    // Saturation on r3
    issue = 1'b1; issue_wa = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #1 check("sat_issue_nostall", {31'h0, stall}, 32'h0);
      tick();
    end
    #1 check("sat_busy3", {31'h0, busy[3]}, 32'h1);
    check("sat_fourth_stall", {31'h0, stall}, 32'h1);
    tick();
    issue = 1'b0; ra1 = 5'd3;
    #1 check("sat_read_stall", {31'h0, stall}, 32'h1);
    we = 1'b1; wa = 5'd3; wd = 32'h1;
    #1 check("sat_wb1_stall", {31'h0, stall}, 32'h1);
    tick();
    wd = 32'h2;
    #1 check("sat_wb2_stall", {31'h0, stall}, 32'h1);
    tick();
    wd = 32'h3;
    #1 check("sat_wb3_busy", {31'h0, busy[3]}, 32'h1);
    check("sat_wb3_release", {31'h0, stall}, 32'h0);
    check("sat_wb3_rd1", rd1, 32'h3);
    tick();
    we = 1'b0;
    #1 check("sat_busy3_clear", {31'h0, busy[3]}, 32'h0);
    check("sat_after_stall", {31'h0, stall}, 32'h0);
    ra1 = 5'd0;

    // Simultaneous inc/dec on r9
    issue = 1'b1; issue_wa = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'h99;
    #1 check("incdec_nostall", {31'h0, stall}, 32'h0);
    tick();
    issue = 1'b0; we = 1'b0; ra1 = 5'd9;
    #1 check("incdec_busy9", {31'h0, busy[9]}, 32'h1);
    check("incdec_stall", {31'h0, stall}, 32'h1);
    we = 1'b1; wa = 5'd9; wd = 32'h9A;
    tick();
    we = 1'b0;
    #1 check("incdec_busy9_clear", {31'h0, busy[9]}, 32'h0);
    check("incdec_rd1", rd1, 32'h9A);
    ra1 = 5'd0;

    // Flush with a concurrent issue and write
    issue = 1'b1; issue_wa = 5'd4;
    tick();
    issue_wa = 5'd6;
    tick();
    issue = 1'b0;
    #1 check("flush_pending", busy, 32'h0000_0050);
    flush = 1'b1; issue = 1'b1; issue_wa = 5'd8;
    we = 1'b1; wa = 5'd10; wd = 32'hA5A5A5A5;
    tick();
    flush = 1'b0; issue = 1'b0; we = 1'b0; ra1 = 5'd10;
    #1 check("flush_busy", busy, 32'h0);
    check("flush_write_kept", rd1, 32'hA5A5A5A5);

    // Reset beats a concurrent write and pending state
    issue = 1'b1; issue_wa = 5'd4;
    tick();
    issue = 1'b0;
    rst = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'h55555555;
    tick();
    rst = 1'b0; we = 1'b0; ra1 = 5'd2; ra2 = 5'd10;
    #1 check("rst_r2", rd1, 32'h0);
    check("rst_r10", rd2, 32'h0);
    check("rst_busy", busy, 32'h0);
    we = 1'b1; wa = 5'd4; wd = 32'h44;
    tick();
    we = 1'b0; ra1 = 5'd4;
    #1 check("late_wb_busy", busy, 32'h0);
    check("late_wb_rd1", rd1, 32'h44);
    check("late_wb_stall", {31'h0, stall}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
